bfm_apbslave_mem: RTL and testbench

APB3 slave memory model for the BFM bench. It answers transfers from the AHB-Lite-to-APB bridge's PSEL/PADDR/PENABLE/PWRITE/PWDATA outputs, backed by a word-addressed RAM. A control word sets programmable wait states and forced slave errors, so master-side PREADY and PSLVERR handling can be exercised. It sits on one PSEL bit of the bridge, as the responder end of that APB link.

---
 rtl/bfm_apbslave_mem.sv | 144 ++++++++++++++
 tb/tb_bfm_apbslave_mem.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfm_apbslave_mem.sv
// APB3 slave memory model: word-addressed RAM behind PSEL, with a CTRL word at the
// top index that programs wait states and forces slave errors on RAM accesses.
module bfm_apbslave_mem #(
    parameter int unsigned AWIDTH      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);

    localparam int unsigned IW    = AWIDTH - 2;
    localparam int unsigned DEPTH = 1 << IW;
    localparam logic [IW-1:0] CTRL_IDX = '1;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q,   cnt_d;
    logic [3:0]      wcnt_q,  wcnt_d;
    logic            ferr_q,  ferr_d;
    logic            err_q,   err_d;
    logic            write_q, write_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_we;

    // Top slot is never written; that index decodes to CTRL instead.
    logic [31:0]     mem_q [DEPTH];

    logic [IW-1:0]   set_idx;
    logic            set_oor;
    logic            set_ctrl;
    logic            set_err;
    logic [31:0]     ctrl_img;
    logic            unused_addr_lsb;

    assign set_idx         = PADDR[AWIDTH-1:2];
    assign set_oor         = |(PADDR >> AWIDTH);
    assign set_ctrl        = (set_idx == CTRL_IDX);
    assign set_err         = set_oor | (ferr_q & ~set_ctrl);
    assign ctrl_img        = {23'b0, ferr_q, 4'b0, wcnt_q};
    assign unused_addr_lsb = ^PADDR[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        ferr_d  = ferr_q;
        err_d   = err_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    idx_d   = set_idx;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = wcnt_q;
                    err_d   = set_err;
                    if (set_err || PWRITE) begin
                        rdata_d = '0;
                    end else if (set_ctrl) begin
                        rdata_d = ctrl_img;
                    end else begin
                        rdata_d = mem_q[set_idx];
                    end
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    rdata_d = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    rdata_d = '0;
                    if (write_q && !err_q) begin
                        if (idx_q == CTRL_IDX) begin
                            wcnt_d = wdata_q[3:0];
                            ferr_d = wdata_q[8];
                        end else begin
                            mem_we = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= 4'(WAIT_STATES);
            ferr_q  <= 1'b0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            ferr_q  <= ferr_d;
            err_q   <= err_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is deliberately outside reset; reset only blocks a commit in flight.
    always_ff @(posedge PCLK) begin
        if (mem_we && !PRESET) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
    assign PSLVERR = PREADY && err_q;
    assign PRDATA  = rdata_q;

endmodule

// File: tb/tb_bfm_apbslave_mem.sv
// Directed bench for bfm_apbslave_mem: wait states, error paths, abort, reset and
// back-to-back traffic against a small scoreboard.
module tb_bfm_apbslave_mem;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic [31:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    int          w;
    logic        e;
    logic [31:0] r;
    logic        g;

    bfm_apbslave_mem #(.AWIDTH(10), .WAIT_STATES(0)) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PADDR   (PADDR),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Called at posedge+1; returns access-phase wait count (-1 on timeout), the
    // PSLVERR/PRDATA seen with PREADY, and whether PREADY/outputs misbehaved outside ACCESS.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            output int waits, output logic err, output logic [31:0] rd,
                            output logic glitch);
        glitch  = 1'b0;
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = wd;
        if (PREADY !== 1'b0) glitch = 1'b1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR   = addr ^ 32'h0000_0004;
        PWDATA  = ~wd;
        waits   = 0;
        while (PREADY !== 1'b1 && waits < 40) begin
            @(posedge PCLK); #1;
            waits++;
        end
        if (waits >= 40) waits = -1;
        err = PSLVERR;
        rd  = PRDATA;
        @(posedge PCLK); #1;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) glitch = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        checks++;
        if (PRDATA !== 32'h0 || PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got PRDATA=%h PREADY=%b PSLVERR=%b want 0/0/0", PRDATA, PREADY, PSLVERR);
        end
        // PENABLE without setup must be ignored
        PSEL = 1'b1; PENABLE = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (PREADY !== 1'b0) begin
            errors++;
            $display("FAIL no_setup_ignored got PREADY=%b want 0", PREADY);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
    endtask

    task automatic test_zero_wait();
        apb_xfer(1'b1, 32'h010, 32'hDEADBEEF, w, e, r, g);
        checks++;
        if (w !== 0 || e !== 1'b0 || g !== 1'b0) begin
            errors++;
            $display("FAIL zw_write got waits=%0d err=%b glitch=%b want 0/0/0", w, e, g);
        end
        apb_xfer(1'b0, 32'h010, 32'h0, w, e, r, g);
        checks++;
        if (w !== 0 || e !== 1'b0 || g !== 1'b0) begin
            errors++;
            $display("FAIL zw_read_timing got waits=%0d err=%b glitch=%b want 0/0/0", w, e, g);
        end
        checks++;
        if (r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL zw_read_data got %h want deadbeef", r);
        end
    endtask

    task automatic test_wait_states();
        apb_xfer(1'b1, 32'h3FC, 32'h3, w, e, r, g);
        checks++;
        if (w !== 0 || e !== 1'b0) begin
            errors++;
            $display("FAIL ws_ctrl_write got waits=%0d err=%b want 0/0", w, e);
        end
        apb_xfer(1'b0, 32'h010, 32'h0, w, e, r, g);
        checks++;
        if (w !== 3 || e !== 1'b0 || g !== 1'b0) begin
            errors++;
            $display("FAIL ws_read_timing got waits=%0d err=%b glitch=%b want 3/0/0", w, e, g);
        end
        checks++;
        if (r !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ws_read_data got %h want deadbeef", r);
        end
        apb_xfer(1'b0, 32'h3FC, 32'h0, w, e, r, g);
        checks++;
        if (w !== 3 || r !== 32'h3) begin
            errors++;
            $display("FAIL ws_ctrl_read got waits=%0d data=%h want 3/00000003", w, r);
        end
        apb_xfer(1'b1, 32'h3FC, 32'hFFFF_FE00, w, e, r, g);
        checks++;
        if (w !== 3) begin
            errors++;
            $display("FAIL ws_ctrl_clear_timing got waits=%0d want 3", w);
        end
        apb_xfer(1'b0, 32'h3FC, 32'h0, w, e, r, g);
        checks++;
        if (w !== 0 || r !== 32'h0) begin
            errors++;
            $display("FAIL ws_ctrl_readback got waits=%0d data=%h want 0/00000000", w, r);
        end
    endtask

    task automatic test_out_of_range();
        apb_xfer(1'b1, 32'h000, 32'h1111_2222, w, e, r, g);
        apb_xfer(1'b1, 32'h400, 32'h1234_5678, w, e, r, g);
        checks++;
        if (e !== 1'b1 || w !== 0) begin
            errors++;
            $display("FAIL oor_write got err=%b waits=%0d want 1/0", e, w);
        end
        apb_xfer(1'b0, 32'h400, 32'h0, w, e, r, g);
        checks++;
        if (e !== 1'b1 || r !== 32'h0) begin
            errors++;
            $display("FAIL oor_read got err=%b data=%h want 1/00000000", e, r);
        end
        apb_xfer(1'b0, 32'h000, 32'h0, w, e, r, g);
        checks++;
        if (e !== 1'b0 || r !== 32'h1111_2222) begin
            errors++;
            $display("FAIL oor_word0_kept got err=%b data=%h want 0/11112222", e, r);
        end
    endtask

    task automatic test_forced_err();
        apb_xfer(1'b1, 32'h020, 32'h0000_0077, w, e, r, g);
        apb_xfer(1'b1, 32'h3FC, 32'h0000_0100, w, e, r, g);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL fe_ctrl_set got err=%b want 0", e);
        end
        apb_xfer(1'b1, 32'h020, 32'h0000_0055, w, e, r, g);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL fe_write_err got err=%b want 1", e);
        end
        apb_xfer(1'b0, 32'h3FC, 32'h0, w, e, r, g);
        checks++;
        if (e !== 1'b0 || r !== 32'h0000_0100) begin
            errors++;
            $display("FAIL fe_ctrl_read got err=%b data=%h want 0/00000100", e, r);
        end
        apb_xfer(1'b1, 32'h3FC, 32'h0, w, e, r, g);
        apb_xfer(1'b0, 32'h020, 32'h0, w, e, r, g);
        checks++;
        if (e !== 1'b0 || r !== 32'h0000_0077) begin
            errors++;
            $display("FAIL fe_word_kept got err=%b data=%h want 0/00000077", e, r);
        end
    endtask

    task automatic test_abort();
        apb_xfer(1'b1, 32'h3FC, 32'h5, w, e, r, g);
        apb_xfer(1'b1, 32'h030, 32'hCAFE_0001, w, e, r, g);
        checks++;
        if (w !== 5 || e !== 1'b0) begin
            errors++;
            $display("FAIL ab_normal_write got waits=%0d err=%b want 5/0", w, e);
        end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h030; PWDATA = 32'h0000_0BAD;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL ab_idle_outputs got PREADY=%b PRDATA=%h PSLVERR=%b want 0/0/0", PREADY, PRDATA, PSLVERR);
        end
        apb_xfer(1'b0, 32'h030, 32'h0, w, e, r, g);
        checks++;
        if (w !== 5 || e !== 1'b0 || r !== 32'hCAFE_0001 || g !== 1'b0) begin
            errors++;
            $display("FAIL ab_after_read got waits=%0d err=%b data=%h glitch=%b want 5/0/cafe0001/0", w, e, r, g);
        end
    endtask

    task automatic test_reset_mid();
        apb_xfer(1'b1, 32'h040, 32'h0BAD_F00D, w, e, r, g);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h040; PWDATA = 32'hFFFF_FFFF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        checks++;
        if (PREADY !== 1'b0 || PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs got PREADY=%b PRDATA=%h PSLVERR=%b want 0/0/0", PREADY, PRDATA, PSLVERR);
        end
        apb_xfer(1'b0, 32'h040, 32'h0, w, e, r, g);
        checks++;
        if (w !== 0 || r !== 32'h0BAD_F00D || e !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_word got waits=%0d data=%h err=%b want 0/0badf00d/0", w, r, e);
        end
        apb_xfer(1'b0, 32'h3FC, 32'h0, w, e, r, g);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_ctrl got %h want 00000000", r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] sb [16];
        int          hist [64];
        int          nh;
        int          slot;
        logic [31:0] d;
        nh = 0;
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) begin
                slot = int'($urandom_range(0, 15));
                d    = $urandom;
                apb_xfer(1'b1, 32'h100 + 32'(slot * 4), d, w, e, r, g);
                sb[slot] = d;
                hist[nh] = slot;
                nh++;
                checks++;
                if (w !== 0 || e !== 1'b0 || g !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_write[%0d] got waits=%0d err=%b glitch=%b want 0/0/0", i, w, e, g);
                end
            end else begin
                slot = hist[$urandom_range(0, nh - 1)];
                apb_xfer(1'b0, 32'h100 + 32'(slot * 4), 32'h0, w, e, r, g);
                checks++;
                if (r !== sb[slot] || w !== 0 || e !== 1'b0 || g !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_read[%0d] got data=%h waits=%0d err=%b glitch=%b want %h/0/0/0",
                             i, r, w, e, g, sb[slot]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_forced_err();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
